bin_to_bcd6: RTL and testbench
==============================

# bin_to_bcd6

Iterative binary-to-BCD converter producing the 6-digit packed BCD count consumed by the BCD rounding stage of the frequency counter. Accepts a BIN_W-bit binary count on a start pulse, runs shift-add-3 (double dabble) one bit per clock, and presents a 24-bit packed BCD result with a one-cycle done pulse. Its bcd_out/done pair drives the rounding stage's BCD_in/start directly.

## Interface
- BIN_W, 20: binary input width; 1..20 (2^20 covers the 6-digit range)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous and active-high
- start  input  1  request conversion; sampled only when busy=0
- bin_in  input  BIN_W  binary count, captured on the accepted start edge
- bcd_out  output  24  packed BCD, digit 5 (hundred-thousands) in [23:20], digit 0 (units) in [3:0]
- done  output  1  one-cycle pulse, bcd_out valid from this cycle
- busy  output  1  high while converting
- ovf  output  1  input exceeded 999999 (see Configuration)

## Operation
- FSM states: IDLE, SHIFT.
- IDLE with start=1: capture bin_in into shift register, clear 24-bit BCD accumulator, bit counter=0, go SHIFT.
- SHIFT, per clock: each of 6 digits ≥5 gets +3, then {bcd_acc, shreg} shifts left 1 bit; counter++.
- When counter reaches BIN_W-1 (last shift): load bcd_out with the shifted result, pulse done, go IDLE.
- start while busy=1 ignored; no queueing.
- bcd_out and ovf hold until the next done; they never change mid-conversion.
- Carry out of digit 5 discarded: raw result = bin_in mod 1,000,000.
- Every digit of bcd_out is 0..9 in all cases.

## Timing
- Reset values: bcd_out=24'h000000, done=0, busy=0, ovf=0, state IDLE, counter 0.
- start accepted at edge k; busy high from k through the cycle before k+BIN_W.
- done high for exactly the cycle following edge k+BIN_W; latency = BIN_W clocks.
- busy=0 during the done cycle; start in that cycle is accepted (back-to-back, one result per BIN_W clocks).
- rst mid-conversion: abort, all outputs to reset values next edge, no done pulse.
- rst and start on the same edge: rst wins.

## Configuration
- BIN2BCD_SAT_EN defined: at capture, bin_in > 999999 registers ovf=1 and the result is forced to 24'h999999 at done; otherwise ovf=0.
- Undefined: ovf tied 0, compare logic absent, result = bin_in mod 1,000,000.

## Structure
- Shared package freq_pkg: BCD_DIGITS=6, BCD_W=24, BCD_MAX_BIN=20'd999999, FSM state typedef.
- Sub-module bcd_digit_adj: combinational 4-bit "+3 if ≥5" correction, instantiated 6 times.
- Top holds FSM, counter, shift register, output registers.

## Test plan
- rst, then bin_in=0, start -> done after 20 clocks, bcd_out=24'h000000, ovf=0.
- bin_in=123456 -> bcd_out=24'h123456 exactly 20 clocks after start; busy high 20 cycles.
- bin_in=999999 then back-to-back start in done cycle with bin_in=5 -> 24'h999999, then 24'h000005 20 clocks later.
- bin_in=1048575 -> with BIN2BCD_SAT_EN: 24'h999999, ovf=1; without: 24'h048575, ovf=0.
- start pulsed mid-conversion with bin_in=7 -> ignored; single done, original result.
- rst asserted 10 clocks into conversion -> no done, bcd_out=0, busy=0; next start converts normally.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-counter BCD path: digit count,
// packed BCD width, largest binary value representable in six digits,
// and the converter FSM state type.
package freq_pkg;

  localparam int BCD_DIGITS = 6;
  localparam int BCD_W      = 24;

  localparam logic [19:0]      BCD_MAX_BIN = 20'd999999;
  localparam logic [BCD_W-1:0] BCD_SAT_VAL = 24'h999999;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/bin_to_bcd6_if.sv
// Bus between the requester and the binary-to-BCD converter.
//
// Handshake: start is a request that the converter takes only while
// busy=0; a start seen while busy=1 is dropped, never queued. done is a
// single-cycle pulse marking bcd_out/ovf valid, and those outputs then
// hold until the following done. dbg_state mirrors the FSM state.
interface bin_to_bcd6_if
  import freq_pkg::*;
#(
  parameter int BIN_W = 20
);

  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic [BCD_W-1:0] bcd_out;
  logic             done;
  logic             busy;
  logic             ovf;
  state_e           dbg_state;

  // Requester side
  modport master (
    output start, bin_in,
    input  bcd_out, done, busy, ovf, dbg_state
  );

  // Converter side
  modport slave (
    input  start, bin_in,
    output bcd_out, done, busy, ovf, dbg_state
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5
// or more so the following left shift carries correctly into the next
// decade.
module bcd_digit_adj (
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  // +3 correction for digits 5..9 (larger codes never occur in the accumulator)
  always_comb begin
    d_out = d_in;
    if (d_in >= 4'd5) begin
      d_out = d_in + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd6.sv
// Iterative binary-to-BCD converter, one bit per clock (shift-add-3).
// A BIN_W-bit value captured on start becomes a 6-digit packed BCD
// result after BIN_W clocks, flagged by a one-cycle done pulse.
// Carries out of the hundred-thousands digit are dropped, so the result
// is bin_in mod 1,000,000.
// Optional feature macro: BIN2BCD_SAT_EN -- inputs above 999999 set ovf
// and saturate the result to 999999.
module bin_to_bcd6
  import freq_pkg::*;
#(
  parameter int BIN_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  bin_to_bcd6_if.slave      bus
);

  localparam int                CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIN_W - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] shreg_q, shreg_d;
  logic [BCD_W-1:0] acc_q, acc_d;
  logic [BCD_W-1:0] bcd_out_q, bcd_out_d;
  logic             done_q, done_d;

  logic [BCD_W-1:0] acc_adj;
  logic [BCD_W-1:0] acc_shift;
  logic [BCD_W-1:0] result;

  // Per-digit +3 correction of the current accumulator
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_in  (acc_q[4*g +: 4]),
      .d_out (acc_adj[4*g +: 4])
    );
  end

  // Corrected accumulator shifted left, taking the next binary bit in;
  // the top bit of digit 5 falls off, which is the mod-1,000,000 wrap.
  assign acc_shift = {acc_adj[BCD_W-2:0], shreg_q[BIN_W-1]};

`ifdef BIN2BCD_SAT_EN
  logic ovf_pend_q, ovf_pend_d;
  logic ovf_q, ovf_d;
  logic in_over;

  // Range check on the incoming value, evaluated at capture time
  assign in_over = 32'(bus.bin_in) > 32'(BCD_MAX_BIN);
  assign result  = ovf_pend_q ? BCD_SAT_VAL : acc_shift;

  // Overflow flag registers: pending flag from capture, visible flag from done
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
    end
  end

  // Latch the range check on capture, publish it on done
  always_comb begin
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    if (state_q == ST_IDLE && bus.start) begin
      ovf_pend_d = in_over;
    end
    if (state_q == ST_SHIFT && cnt_q == CNT_LAST) begin
      ovf_d = ovf_pend_q;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign result  = acc_shift;
  assign bus.ovf = 1'b0;
`endif

  // State, counter, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      acc_q     <= '0;
      bcd_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      acc_q     <= acc_d;
      bcd_out_q <= bcd_out_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: capture in IDLE, one shift per clock in SHIFT
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    acc_d     = acc_q;
    bcd_out_d = bcd_out_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shreg_d = bus.bin_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d   = acc_shift;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          bcd_out_d = result;
          done_d    = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.bcd_out   = bcd_out_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == ST_SHIFT);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bin_to_bcd6.sv
// Directed bench for bin_to_bcd6 with BIN_W=20. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_bin_to_bcd6;
  import freq_pkg::*;

  localparam int BIN_W = 20;

  logic clk;
  logic rst;

  bin_to_bcd6_if #(.BIN_W(BIN_W)) bus ();

  bin_to_bcd6 #(.BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_err;
  int cyc;
  int t0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: one-cycle start pulse, records the accepting edge
  task automatic do_start(input logic [BIN_W-1:0] v);
    bus.start  = 1'b1;
    bus.bin_in = v;
    tick();
    bus.start  = 1'b0;
    t0 = cyc;
  endtask

  // Bounded wait for done, then compare latency and result
  task automatic wait_done(input string tag, input logic [23:0] exp_bcd, input logic exp_ovf);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(cyc - t0), 32'd20);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_bcd"}, 32'(bus.bcd_out), 32'(exp_bcd));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
  endtask

  logic [23:0] exp_big;
  logic        exp_big_ovf;
  logic        exp_after_ovf;

  initial begin
    int bc;
    int n;
    int seen_done;
    n_checks = 0;
    n_err    = 0;
    cyc      = 0;
    t0       = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = '0;

`ifdef BIN2BCD_SAT_EN
    exp_big     = 24'h999999;
    exp_big_ovf = 1'b1;
`else
    exp_big     = 24'h048575;
    exp_big_ovf = 1'b0;
`endif
    exp_after_ovf = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_bcd", 32'(bus.bcd_out), 32'h0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // Zero input
    do_start(20'd0);
    check("zero_busy_after_start", 32'(bus.busy), 32'd1);
    wait_done("zero", 24'h000000, 1'b0);
    tick();
    check("zero_done_one_cycle", 32'(bus.done), 32'd0);

    // 123456 with busy-cycle count
    do_start(20'd123456);
    bc = 0;
    n  = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) bc++;
      tick();
      n++;
    end
    check("p123456_busy_cycles", 32'(bc), 32'd20);
    check("p123456_latency", 32'(cyc - t0), 32'd20);
    check("p123456_bcd", 32'(bus.bcd_out), 32'h123456);
    check("p123456_busy_in_done", 32'(bus.busy), 32'd0);
    tick();
    check("p123456_hold", 32'(bus.bcd_out), 32'h123456);

    // 999999 then back-to-back start in the done cycle
    do_start(20'd999999);
    wait_done("p999999", 24'h999999, 1'b0);
    do_start(20'd5);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    check("b2b_hold_prev", 32'(bus.bcd_out), 32'h999999);
    wait_done("b2b5", 24'h000005, 1'b0);
    tick();

    // Largest 20-bit input
    do_start(20'd1048575);
    wait_done("max20", exp_big, exp_big_ovf);
    tick();
    check("max20_ovf_hold", 32'(bus.ovf), 32'(exp_big_ovf));

    // Next in-range conversion clears ovf
    do_start(20'd7);
    check("ovf_hold_mid", 32'(bus.ovf), 32'(exp_big_ovf));
    wait_done("after_max", 24'h000007, exp_after_ovf);
    tick();

    // Start mid-conversion is ignored; outputs hold meanwhile
    do_start(20'd654321);
    for (int i = 0; i < 5; i++) tick();
    check("mid_hold_bcd", 32'(bus.bcd_out), 32'h000007);
    bus.start  = 1'b1;
    bus.bin_in = 20'd7;
    tick();
    bus.start  = 1'b0;
    wait_done("ignore_start", 24'h654321, 1'b0);
    tick();
    check("ignore_single_done", 32'(bus.done), 32'd0);
    check("ignore_not_busy", 32'(bus.busy), 32'd0);

    // Reset 10 clocks into a conversion
    do_start(20'd123456);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    check("abort_bcd", 32'(bus.bcd_out), 32'h0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.done === 1'b1) seen_done++;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    do_start(20'd42);
    wait_done("post_abort", 24'h000042, 1'b0);
    tick();

    // rst and start on the same edge: rst wins
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.bin_in = 20'd99;
    tick();
    bus.start  = 1'b0;
    rst        = 1'b0;
    check("rst_wins_busy", 32'(bus.busy), 32'd0);
    check("rst_wins_bcd", 32'(bus.bcd_out), 32'h0);
    tick();
    check("rst_wins_idle", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
